// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: CSR map, controller states and burst geometry shared by memory_to_stream.
package mem_stream_pkg;
    typedef logic [1:0] CsrAddr_t;
    localparam CsrAddr_t CSR_LEN = 2'd0;
    localparam CsrAddr_t CSR_ADDR = 2'd1;
    localparam CsrAddr_t CSR_IRQ = 2'd2;
    localparam CsrAddr_t CSR_STATUS = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int BURST_LEN = 2;
    localparam int BURST_BYTES = 64;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; pop on empty and push on full without pop are dropped.
module sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    always_comb begin
        full = count == (AW+1)'(DEPTH);
        empty = count == '0;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
    end
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/memory_to_stream.sv
// memory_to_stream: CSR-programmed DMA reading 2-beat 256-bit bursts into a 512-bit stream.
// Completion interrupt is built only with MEMORY_TO_STREAM_IRQ_EN defined; otherwise irq reads 0.
module memory_to_stream
    import mem_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           csr_write,
    input  logic           csr_read,
    input  CsrAddr_t       csr_address,
    input  logic [31:0]    csr_writedata,
    output logic [31:0]    csr_readdata,
    output logic           m_read,
    output logic [32:0]    m_address,
    output logic [1:0]     m_burstcount,
    input  logic [255:0]   m_readdata,
    input  logic           m_readdatavalid,
    input  logic           m_waitrequest,
    output logic [511:0]   src_data,
    output logic           src_valid,
    input  logic           src_ready,
    output logic           irq
);
    localparam int CW = $clog2(FIFO_DEPTH);
    state_t state, state_next;
    logic [31:0] issue_cnt, deliver_cnt;
    logic [CW:0] in_flight, fifo_count;
    logic [CW+1:0] occupancy;
    logic [255:0] held_beat;
    logic held, fifo_full, fifo_empty, busy, credit;
    logic len_go, addr_wr, accept, beat, push, pop, last_issue, last_deliver;

    always_comb begin
        len_go = csr_write && csr_address == CSR_LEN && !busy && csr_writedata != '0;
        addr_wr = csr_write && csr_address == CSR_ADDR && !busy;
        // Every accepted burst becomes exactly one element, so this bounds FIFO fill.
        occupancy = (CW+2)'(fifo_count) + (CW+2)'(in_flight);
        credit = occupancy < (CW+2)'(FIFO_DEPTH) && !fifo_full;
        accept = m_read && !m_waitrequest;
        beat = m_readdatavalid && in_flight != '0;
        push = beat && held;
        pop = src_valid && src_ready;
        last_issue = accept && issue_cnt == 32'd1;
        last_deliver = pop && deliver_cnt == 32'd1 && state == DRAIN;
    end

    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (len_go ? ISSUE : IDLE) :
                     state == ISSUE ? (last_issue ? DRAIN : ISSUE) :
                     (last_deliver ? IDLE : DRAIN);
    end

    always_comb begin
        busy = state != IDLE;
        m_read = state == ISSUE && credit;
        m_burstcount = 2'(BURST_LEN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_address <= '0;
            issue_cnt <= '0;
            deliver_cnt <= '0;
            in_flight <= '0;
            held <= 1'b0;
            held_beat <= '0;
            csr_readdata <= '0;
        end else begin
            if (addr_wr) m_address <= {1'b0, csr_writedata};
            else if (accept) m_address <= m_address + 33'(BURST_BYTES);
            if (len_go) begin
                issue_cnt <= csr_writedata;
                deliver_cnt <= csr_writedata;
            end else begin
                if (accept) issue_cnt <= issue_cnt - 32'd1;
                if (pop) deliver_cnt <= deliver_cnt - 32'd1;
            end
            in_flight <= in_flight + (CW+1)'(accept) - (CW+1)'(push);
            if (beat) held <= !held;
            if (beat && !held) held_beat <= m_readdata;
            if (csr_read) csr_readdata <= csr_address == CSR_LEN ? deliver_cnt :
                                         csr_address == CSR_ADDR ? m_address[31:0] :
                                         csr_address == CSR_STATUS ? {30'b0, irq, busy} : '0;
        end
    end

`ifdef MEMORY_TO_STREAM_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) irq <= 1'b0;
        else if (last_deliver) irq <= 1'b1;
        else if (csr_write && csr_address == CSR_IRQ) irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

    sync_fifo #(.WIDTH(512), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({held_beat, m_readdata}),
        .pop       (pop),
        .pop_data  (src_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
    assign src_valid = !fifo_empty;
endmodule

// File: tb/tb_memory_to_stream.sv
// tb_memory_to_stream: memory slave + transfer-level model of memory_to_stream with directed scenarios.
module tb_memory_to_stream;
    localparam int DEPTH = 8;
`ifdef MEMORY_TO_STREAM_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    logic clock = 1'b0, reset;
    logic csr_write, csr_read;
    logic [1:0] csr_address;
    logic [31:0] csr_writedata, csr_readdata;
    logic m_read, m_readdatavalid, m_waitrequest;
    logic [32:0] m_address;
    logic [1:0] m_burstcount;
    logic [255:0] m_readdata;
    logic [511:0] src_data;
    logic src_valid, src_ready, irq;
    int total = 0, bad = 0, cyc = 0, stall_seen = 0, stall_left = 0;
    longint issued = 0, popped = 0, len_exp = 0, stall_at = -1;
    logic busy_exp = 1'b0, irq_exp = 1'b0, prev_stall = 1'b0;
    logic [32:0] addr_exp = '0, base_exp = '0, prev_addr = '0;
    logic [32:0] rq[$];
    int rq_cyc[$];
    logic [32:0] addr_log[$];
    logic [511:0] data_log[$];
    logic [31:0] rd;

    memory_to_stream #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .csr_write(csr_write), .csr_read(csr_read), .csr_address(csr_address),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .m_read(m_read), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .irq(irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [255:0] beat_of(logic [32:0] a, logic k);
        return {8{a[31:0] + 32'(k)}};
    endfunction

    task automatic check(string name, logic [511:0] got, logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Memory side: beats of the oldest accepted burst, back to back, two cycles after acceptance.
    initial begin
        logic phase = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        forever begin
            @(posedge clock); #1;
            if (rq.size() > 0 && cyc >= rq_cyc[0] + 2) begin
                m_readdatavalid = 1'b1;
                m_readdata = beat_of(rq[0], phase);
                if (phase) begin
                    void'(rq.pop_front());
                    void'(rq_cyc.pop_front());
                end
                phase = !phase;
            end else begin
                m_readdatavalid = 1'b0;
                m_readdata = '0;
            end
        end
    end

    initial begin
        m_waitrequest = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (stall_left > 0 && m_read && issued == stall_at) begin
                m_waitrequest = 1'b1;
                stall_left--;
            end else m_waitrequest = 1'b0;
        end
    end

    // Transfer model: element i of a transfer is the burst at base+64*i; credit = issued - delivered.
    always @(negedge clock) begin
        logic busy0, last;
        if (m_read && !m_waitrequest) begin
            rq.push_back(m_address);
            rq_cyc.push_back(cyc);
        end
        if (reset) begin
            busy_exp = 1'b0; len_exp = 0; issued = 0; popped = 0;
            addr_exp = '0; irq_exp = 1'b0; prev_stall = 1'b0;
        end else begin
            busy0 = busy_exp;
            last = 1'b0;
            check("m_read", m_read, busy_exp && issued < len_exp && issued - popped < DEPTH);
            check("irq", irq, irq_exp);
            if (prev_stall) begin
                check("hold_read", m_read, 1'b1);
                check("hold_addr", m_address, prev_addr);
            end
            if (m_read && !m_waitrequest) begin
                check("addr", m_address, addr_exp);
                check("burstcount", m_burstcount, 2);
                addr_log.push_back(m_address);
                addr_exp = addr_exp + 33'd64;
                issued++;
            end
            if (m_read && m_waitrequest) stall_seen++;
            prev_stall = m_read && m_waitrequest;
            prev_addr = m_address;
            if (src_valid && src_ready) begin
                if (busy_exp && popped < len_exp) begin
                    check("src_data", src_data, {beat_of(base_exp + 33'(64 * popped), 1'b0),
                                                 beat_of(base_exp + 33'(64 * popped), 1'b1)});
                    data_log.push_back(src_data);
                    popped++;
                    last = popped == len_exp;
                    if (last) busy_exp = 1'b0;
                end else check("spurious_pop", src_valid, 1'b0);
            end
            if (csr_write && csr_address == 2'd1 && !busy0) addr_exp = {1'b0, csr_writedata};
            if (csr_write && csr_address == 2'd0 && !busy0 && csr_writedata != 0) begin
                busy_exp = 1'b1; len_exp = csr_writedata; issued = 0; popped = 0; base_exp = addr_exp;
            end
            if (IRQ_ON && last) irq_exp = 1'b1;
            else if (csr_write && csr_address == 2'd2) irq_exp = 1'b0;
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic csr_wr(logic [1:0] a, logic [31:0] d);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        step();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(logic [1:0] a, output logic [31:0] d);
        csr_read = 1'b1; csr_address = a;
        step();
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while ((busy_exp || rq.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        check({name, "_timeout"}, n < 2000, 1'b1);
        step(2);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
    endtask

    initial begin
        int n;
        reset = 1'b1; csr_write = 1'b0; csr_read = 1'b0; csr_address = '0; csr_writedata = '0; src_ready = 1'b0;
        step(3);
        reset = 1'b0;
        check("rst_src_valid", src_valid, 1'b0);
        check("rst_m_read", m_read, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_readdata", csr_readdata, 32'd0);
        csr_rd(2'd3, rd);
        check("rst_status", rd, 32'd0);

        // Single element from 0x1000
        src_ready = 1'b1;
        clear_logs();
        csr_wr(2'd1, 32'h1000);
        csr_wr(2'd0, 32'd1);
        wait_done("t1");
        check("t1_nreads", addr_log.size(), 1);
        check("t1_addr", addr_log[0], 33'h1000);
        check("t1_data", data_log[0], {{8{32'h1000}}, {8{32'h1001}}});
        check("t1_irq", irq, IRQ_ON);
        csr_rd(2'd3, rd);
        check("t1_status", rd, {IRQ_ON, 1'b0});
        csr_rd(2'd0, rd);
        check("t1_len_left", rd, 32'd0);
        csr_rd(2'd1, rd);
        check("t1_addr_rd", rd, 32'h1040);

        // Three-cycle waitrequest on the second read
        csr_wr(2'd2, 32'd0);
        check("t2_irq_clr", irq, 1'b0);
        clear_logs();
        stall_seen = 0; stall_at = 1; stall_left = 3;
        csr_wr(2'd1, 32'h0);
        csr_wr(2'd0, 32'd4);
        wait_done("t2");
        check("t2_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_addr", addr_log[i], 33'(64 * i));
        check("t2_stalls", stall_seen, 3);
        check("t2_nout", data_log.size(), 4);
        stall_at = -1;

        // Back-pressure: credit limits outstanding bursts to the FIFO depth
        csr_wr(2'd2, 32'd0);
        src_ready = 1'b0;
        clear_logs();
        csr_wr(2'd1, 32'h2000);
        csr_wr(2'd0, 32'd20);
        step(40);
        check("t3_nreads_blocked", addr_log.size(), 8);
        check("t3_m_read_off", m_read, 1'b0);
        check("t3_src_valid", src_valid, 1'b1);
        csr_rd(2'd3, rd);
        check("t3_status_busy", rd, 32'd1);
        csr_rd(2'd0, rd);
        check("t3_len_left", rd, 32'd20);
        src_ready = 1'b1;
        wait_done("t3");
        check("t3_nout", data_log.size(), 20);
        check("t3_last", data_log[19], {{8{32'h24C0}}, {8{32'h24C1}}});
        check("t3_irq", irq, IRQ_ON);

        // IRQ write coinciding with completion: set wins
        clear_logs();
        csr_wr(2'd1, 32'h3000);
        csr_wr(2'd0, 32'd1);
        n = 0;
        while (!src_valid && n < 100) begin
            step();
            n++;
        end
        check("t4_wait_valid", src_valid, 1'b1);
        csr_wr(2'd2, 32'd0);
        check("t4_irq_set_wins", irq, IRQ_ON);
        wait_done("t4");
        csr_wr(2'd2, 32'd0);
        check("t4_irq_cleared", irq, 1'b0);

        // Reset mid-transfer, then a fresh transfer
        clear_logs();
        csr_wr(2'd1, 32'h4000);
        csr_wr(2'd0, 32'd10);
        n = 0;
        while (issued < 3 && n < 100) begin
            step();
            n++;
        end
        check("t5_issued3", issued >= 3, 1'b1);
        check("t5_beats_pending", rq.size() > 0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        while (rq.size() != 0 && n < 100) begin
            check("t5_src_valid", src_valid, 1'b0);
            step();
            n++;
        end
        step(2);
        check("t5_src_valid_after", src_valid, 1'b0);
        csr_rd(2'd3, rd);
        check("t5_status", rd, 32'd0);
        clear_logs();
        csr_wr(2'd1, 32'h5000);
        csr_wr(2'd0, 32'd1);
        wait_done("t5");
        check("t5_nout", data_log.size(), 1);
        check("t5_data", data_log[0], {{8{32'h5000}}, {8{32'h5001}}});

        // LEN/ADDR writes while busy are ignored; LEN=0 while idle does nothing
        clear_logs();
        csr_wr(2'd1, 32'h6000);
        csr_wr(2'd0, 32'd2);
        csr_wr(2'd0, 32'd5);
        csr_wr(2'd1, 32'h9999);
        wait_done("t6");
        check("t6_nout", data_log.size(), 2);
        check("t6_nreads", addr_log.size(), 2);
        csr_rd(2'd1, rd);
        check("t6_addr_rd", rd, 32'h6080);
        csr_wr(2'd0, 32'd0);
        step(3);
        csr_rd(2'd3, rd);
        check("t6_len0_status", rd, {IRQ_ON, 1'b0});
        check("t6_len0_m_read", m_read, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
